// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter: FSM encoding, clog2 and the grant-index width macro.
// The optional fixed-priority feature is enabled by defining UART_ARB_PRIO_EN.
`ifndef UART_TX_ARBITER_PKG_SV
`define UART_TX_ARBITER_PKG_SV

package uart_tx_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`define UART_ARB_ID_W(n) (((n) > 1) ? uart_tx_arbiter_pkg::clog2(n) : 1)

`endif

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin find-first: first set request at or above the pointer, with wrap-around.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_found
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return ID_W'(s);
  endfunction

  // Scan farthest-first so the nearest request above the pointer is the final assignment.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(i_ptr, k)]) begin
        o_idx   = wrap_idx(i_ptr, k);
        o_found = 1'b1;
      end else begin
        o_idx   = o_idx;
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte stream; a grant is held for a whole message or MAX_BURST bytes.
// Define UART_ARB_PRIO_EN to make requester 0 win every arbitration it takes part in.
import uart_tx_arbiter_pkg::*;

module uart_tx_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 16,
  localparam int ID_W       = `UART_ARB_ID_W(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  arb_state_e            r_state, w_state_nxt;
  logic [ID_W-1:0]       r_ptr, w_ptr_nxt;
  logic [ID_W-1:0]       r_grant_id, w_grant_nxt;
  logic [CNT_W-1:0]      r_burst_cnt, w_burst_nxt;
  logic                  r_tx_valid, w_tx_valid_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;

  logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];
  logic [ID_W-1:0]       w_rr_idx, w_win_idx;
  logic                  w_rr_found, w_slot_free, w_accept, w_release, w_arb;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

`ifdef UART_ARB_PRIO_EN
  assign w_win_idx = req_valid[0] ? {ID_W{1'b0}} : w_rr_idx;
`else
  assign w_win_idx = w_rr_idx;
`endif

  // The output register can take a byte when empty or draining this cycle.
  assign w_slot_free = !r_tx_valid || tx_ready;
  assign w_accept    = (r_state == ST_LOCK) && req_valid[r_grant_id] && w_slot_free;
  assign w_release   = w_accept && (req_last[r_grant_id] ||
                                    (r_burst_cnt == CNT_W'(MAX_BURST - 1)));
  assign w_arb       = (r_state == ST_IDLE) && w_rr_found && w_slot_free;

  // Only the owner sees ready, and only while locked.
  always_comb begin
    req_ready = '0;
    if (r_state == ST_LOCK) begin
      req_ready[r_grant_id] = w_slot_free;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state, grant, pointer and burst bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant_id;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_arb) begin
          w_state_nxt = ST_LOCK;
          w_grant_nxt = w_win_idx;
          w_burst_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (w_accept) begin
          w_burst_nxt = r_burst_cnt + CNT_W'(1);
        end else begin
          w_burst_nxt = r_burst_cnt;
        end
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = (r_grant_id == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                           : r_grant_id + ID_W'(1);
        end else begin
          w_state_nxt = ST_LOCK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Single output register stage toward the serializer.
  always_comb begin
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    if (w_accept) begin
      w_tx_valid_nxt = 1'b1;
      w_tx_data_nxt  = w_req_bytes[r_grant_id];
    end else if (r_tx_valid && tx_ready) begin
      w_tx_valid_nxt = 1'b0;
    end else begin
      w_tx_valid_nxt = r_tx_valid;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant_id  <= w_grant_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;
  assign busy     = (r_state == ST_LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4); inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int first_id;
  int second_id;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid[i]      = v;
    req_last[i]       = l;
    req_data[i*8 +: 8] = d;
  endtask

  initial begin
`ifdef UART_ARB_PRIO_EN
    first_id  = 0;
    second_id = 2;
`else
    first_id  = 2;
    second_id = 0;
`endif
    rstn = 1'b0; req_valid = 4'h0; req_last = 4'h0; req_data = 32'h0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;

    // Contention: req0 and req2, 2-byte messages, pointer starts at 0
    set_req(0, 1'b1, 1'b0, 8'hA0);
    set_req(2, 1'b1, 1'b0, 8'hC0);
    tick();
    chk("ct_arb_busy", {31'd0, busy}, 32'd1);
    chk("ct_arb_grant", {30'd0, grant_id}, 32'd0);
    chk("ct_arb_txv", {31'd0, tx_valid}, 32'd0);
    chk("ct_ready0", {28'd0, req_ready}, 32'h1);
    tick();
    chk("ct_a0", {24'd0, tx_data}, 32'hA0);
    set_req(0, 1'b1, 1'b1, 8'hA1);
    tick();
    chk("ct_a1", {24'd0, tx_data}, 32'hA1);
    chk("ct_rel0_busy", {31'd0, busy}, 32'd0);
    set_req(0, 1'b0, 1'b0, 8'h00);
    tick();
    chk("ct_grant2", {30'd0, grant_id}, 32'd2);
    chk("ct_drain", {31'd0, tx_valid}, 32'd0);
    tick();
    chk("ct_c0", {24'd0, tx_data}, 32'hC0);
    set_req(2, 1'b1, 1'b1, 8'hC1);
    tick();
    chk("ct_c1", {24'd0, tx_data}, 32'hC1);
    chk("ct_rel2_busy", {31'd0, busy}, 32'd0);
    set_req(2, 1'b0, 1'b0, 8'h00);
    tick();
    chk("ct_idle_txv", {31'd0, tx_valid}, 32'd0);

    // Single message from req1; req2 pending is ignored. Pointer 3 picks req1 over req2.
    set_req(1, 1'b1, 1'b0, 8'h41);
    set_req(2, 1'b1, 1'b1, 8'hC2);
    tick();
    chk("sm_grant1", {30'd0, grant_id}, 32'd1);
    chk("sm_ready", {28'd0, req_ready}, 32'h2);
    chk("sm_arb_txv", {31'd0, tx_valid}, 32'd0);
    tick();
    chk("sm_41", {24'd0, tx_data}, 32'h41);
    chk("sm_41_v", {31'd0, tx_valid}, 32'd1);
    set_req(1, 1'b1, 1'b0, 8'h42);
    tick();
    chk("sm_42", {24'd0, tx_data}, 32'h42);
    chk("sm_42_grant", {30'd0, grant_id}, 32'd1);
    set_req(1, 1'b1, 1'b1, 8'h43);
    tick();
    chk("sm_43", {24'd0, tx_data}, 32'h43);
    chk("sm_rel_busy", {31'd0, busy}, 32'd0);
    chk("sm_hold_grant", {30'd0, grant_id}, 32'd1);
    set_req(1, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b1, 8'hA2);

    // Pointer now 2 with req0 and req2 pending.
    tick();
    chk("pr_first", {30'd0, grant_id}, first_id);
    chk("pr_first_txv", {31'd0, tx_valid}, 32'd0);
    tick();
    chk("pr_first_data", {24'd0, tx_data}, (first_id == 0) ? 32'hA2 : 32'hC2);
    chk("pr_first_rel", {31'd0, busy}, 32'd0);
    set_req(first_id, 1'b0, 1'b0, 8'h00);
    tick();
    chk("pr_second", {30'd0, grant_id}, second_id);
    tick();
    chk("pr_second_data", {24'd0, tx_data}, (second_id == 0) ? 32'hA2 : 32'hC2);
    set_req(second_id, 1'b0, 1'b0, 8'h00);
    tick();
    chk("pr_idle_txv", {31'd0, tx_valid}, 32'd0);

    // Burst cap of 4: req3 streams without last, req1 arrives meanwhile.
    set_req(3, 1'b1, 1'b0, 8'hD0);
    tick();
    chk("bc_grant3", {30'd0, grant_id}, 32'd3);
    tick();
    chk("bc_d0", {24'd0, tx_data}, 32'hD0);
    set_req(3, 1'b1, 1'b0, 8'hD1);
    set_req(1, 1'b1, 1'b1, 8'hB1);
    chk("bc_ready3", {28'd0, req_ready}, 32'h8);
    tick();
    chk("bc_d1", {24'd0, tx_data}, 32'hD1);
    set_req(3, 1'b1, 1'b0, 8'hD2);
    tick();
    chk("bc_d2", {24'd0, tx_data}, 32'hD2);
    chk("bc_d2_busy", {31'd0, busy}, 32'd1);
    set_req(3, 1'b1, 1'b0, 8'hD3);
    tick();
    chk("bc_d3", {24'd0, tx_data}, 32'hD3);
    chk("bc_cap_rel", {31'd0, busy}, 32'd0);
    set_req(3, 1'b1, 1'b0, 8'hD4);
    tick();
    chk("bc_grant1", {30'd0, grant_id}, 32'd1);
    tick();
    chk("bc_b1", {24'd0, tx_data}, 32'hB1);
    set_req(1, 1'b0, 1'b0, 8'h00);
    tick();
    chk("bc_regrant3", {30'd0, grant_id}, 32'd3);
    tick();
    chk("bc_d4", {24'd0, tx_data}, 32'hD4);
    set_req(3, 1'b0, 1'b0, 8'hEE);
    repeat (2) tick();
    chk("gap_busy", {31'd0, busy}, 32'd1);
    chk("gap_grant", {30'd0, grant_id}, 32'd3);
    chk("gap_txv", {31'd0, tx_valid}, 32'd0);
    set_req(3, 1'b1, 1'b0, 8'hD5);
    tick();
    chk("bc_d5", {24'd0, tx_data}, 32'hD5);
    chk("bc_d5_v", {31'd0, tx_valid}, 32'd1);

    // Asynchronous reset while a byte is held.
    rstn = 1'b0;
    #1;
    chk("ar_txv", {31'd0, tx_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_data", {24'd0, tx_data}, 32'd0);
    tick();
    rstn = 1'b1;
    set_req(1, 1'b1, 1'b0, 8'h51);
    set_req(3, 1'b1, 1'b0, 8'hD6);

    // Pointer back at 0 so req1 beats req3; then backpressure on req1's message.
    tick();
    chk("ar_ptr_grant", {30'd0, grant_id}, 32'd1);
    tick();
    chk("bp_51", {24'd0, tx_data}, 32'h51);
    set_req(1, 1'b1, 1'b0, 8'h52);
    tx_ready = 1'b0;
    #1;
    chk("bp_ready_off", {28'd0, req_ready}, 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_v", {31'd0, tx_valid}, 32'd1);
      chk("bp_hold_d", {24'd0, tx_data}, 32'h51);
      chk("bp_hold_rdy", {28'd0, req_ready}, 32'h0);
    end
    tx_ready = 1'b1;
    #1;
    chk("bp_ready_on", {28'd0, req_ready}, 32'h2);
    tick();
    chk("bp_52", {24'd0, tx_data}, 32'h52);
    set_req(1, 1'b1, 1'b1, 8'h53);
    tick();
    chk("bp_53", {24'd0, tx_data}, 32'h53);
    chk("bp_rel", {31'd0, busy}, 32'd0);
    set_req(1, 1'b0, 1'b0, 8'h00);
    set_req(3, 1'b0, 1'b0, 8'h00);
    tick();
    chk("end_txv", {31'd0, tx_valid}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
